// File: rtl/bsh_issue_if.sv
// Stream and shifter-side signals of the barrel-shifter issue stage.
// Slave modport is the issue controller; master is whatever drives and consumes it.
interface bsh_issue_if #(
   parameter int DATA_WIDTH = 8,
   parameter int AMT_WIDTH  = 8,
   parameter int DEPTH      = 4
);
   localparam int SHIFT_WIDTH = ((1 << $clog2(DATA_WIDTH)) == DATA_WIDTH) ?
                                $clog2(DATA_WIDTH) : $clog2(DATA_WIDTH) + 1;
   localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0]  data_in;
   logic [AMT_WIDTH-1:0]   shift_amt_in;
   logic                   valid_in;
   logic                   ready_out;
   logic [DATA_WIDTH-1:0]  bsh_data_out;
   logic [SHIFT_WIDTH-1:0] bsh_shift_out;
   logic [DATA_WIDTH-1:0]  bsh_result_in;
   logic [DATA_WIDTH-1:0]  data_out;
   logic                   valid_out;
   logic                   ready_in;
   logic [CNT_WIDTH-1:0]   count_out;

   modport slave (
      input  data_in, shift_amt_in, valid_in, bsh_result_in, ready_in,
      output ready_out, bsh_data_out, bsh_shift_out, data_out, valid_out, count_out
   );

   modport master (
      output data_in, shift_amt_in, valid_in, bsh_result_in, ready_in,
      input  ready_out, bsh_data_out, bsh_shift_out, data_out, valid_out, count_out
   );
endinterface

// File: rtl/bsh_issue_ctrl.sv
// Issue stage for a combinational rotate-left barrel shifter: small command FIFO,
// modulo reduction of the rotate amount at push time, registered valid/ready output.
module bsh_issue_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int AMT_WIDTH  = 8,
   parameter int DEPTH      = 4
) (
   input logic        clk,
   input logic        rst,
   bsh_issue_if.slave bus
);
   localparam int SHIFT_WIDTH = ((1 << $clog2(DATA_WIDTH)) == DATA_WIDTH) ?
                                $clog2(DATA_WIDTH) : $clog2(DATA_WIDTH) + 1;
   localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;
   localparam int PTR_WIDTH   = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0]  r_data_mem  [DEPTH];
   logic [SHIFT_WIDTH-1:0] r_shift_mem [DEPTH];
   logic [PTR_WIDTH-1:0]   r_wr_ptr;
   logic [PTR_WIDTH-1:0]   r_rd_ptr;
   logic [CNT_WIDTH-1:0]   r_count;
   logic [DATA_WIDTH-1:0]  r_data_out;
   logic                   r_valid_out;

   logic                   w_empty;
   logic                   w_full;
   logic                   w_push;
   logic                   w_pop;
   logic [AMT_WIDTH-1:0]   w_amt_mod;
   logic [SHIFT_WIDTH-1:0] w_amt_red;

   generate
      if ((1 << SHIFT_WIDTH) == DATA_WIDTH) begin : g_pow2
         assign w_amt_mod = bus.shift_amt_in & AMT_WIDTH'(DATA_WIDTH - 1);
      end else begin : g_mod
         assign w_amt_mod = bus.shift_amt_in % AMT_WIDTH'(DATA_WIDTH);
      end

      // Result is already < DATA_WIDTH, so the dropped high bits are always zero.
      if (AMT_WIDTH > SHIFT_WIDTH) begin : g_trunc
         logic w_unused_hi;
         assign w_amt_red   = w_amt_mod[SHIFT_WIDTH-1:0];
         assign w_unused_hi = ^w_amt_mod[AMT_WIDTH-1:SHIFT_WIDTH];
      end else begin : g_ext
         assign w_amt_red = SHIFT_WIDTH'(w_amt_mod);
      end
   endgenerate

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
   assign w_push  = bus.valid_in && !w_full;
   assign w_pop   = !w_empty && (!r_valid_out || bus.ready_in);

   assign bus.ready_out     = !w_full;
   assign bus.bsh_data_out  = w_empty ? '0 : r_data_mem[r_rd_ptr];
   assign bus.bsh_shift_out = w_empty ? '0 : r_shift_mem[r_rd_ptr];
   assign bus.data_out      = r_data_out;
   assign bus.valid_out     = r_valid_out;
   assign bus.count_out     = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data_mem[i]  <= '0;
            r_shift_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_data_mem[r_wr_ptr]  <= bus.data_in;
            r_shift_mem[r_wr_ptr] <= w_amt_red;
            r_wr_ptr              <= r_wr_ptr + PTR_WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_WIDTH'(1);
            2'b01:   r_count <= r_count - CNT_WIDTH'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A pop always refills the output register, so it wins over a plain drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
      end else if (w_pop) begin
         r_data_out  <= bus.bsh_result_in;
         r_valid_out <= 1'b1;
      end else if (r_valid_out && bus.ready_in) begin
         r_valid_out <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bsh_issue_ctrl.sv
// Directed bench for bsh_issue_ctrl with a behavioural rotate-left shifter attached
// and a scoreboard of expected results in acceptance order.
module tb_bsh_issue_ctrl;
   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   logic [7:0] sb[$];

   bsh_issue_if #(.DATA_WIDTH(8), .AMT_WIDTH(8), .DEPTH(4)) bus ();

   bsh_issue_ctrl #(.DATA_WIDTH(8), .AMT_WIDTH(8), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [7:0] rol8(input logic [7:0] d, input int s);
      logic [7:0] r;
      r = (d << s) | (d >> (8 - s));
      return r;
   endfunction

   assign bus.bsh_result_in = rol8(bus.bsh_data_out, int'(bus.bsh_shift_out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      if (bus.valid_out && bus.ready_in) begin
         check("sb_has_entry", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) check("result", bus.data_out, sb.pop_front());
      end
      if (bus.valid_in && bus.ready_out && !rst)
         sb.push_back(rol8(bus.data_in, int'(bus.shift_amt_in) % 8));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] d, input logic [7:0] a, input logic v);
      bus.data_in      = d;
      bus.shift_amt_in = a;
      bus.valid_in     = v;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst     = 1'b1;
      drive(8'h00, 8'h00, 1'b0);
      bus.ready_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready_out", bus.ready_out, 1);
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_count", bus.count_out, 0);
      check("rst_bsh_data", bus.bsh_data_out, 0);
      check("rst_bsh_shift", bus.bsh_shift_out, 0);
      rst = 1'b0;

      // basic rotate
      bus.ready_in = 1'b1;
      drive(8'h81, 8'd1, 1'b1);
      step();
      drive(8'h00, 8'd0, 1'b0);
      check("basic_bsh_shift", bus.bsh_shift_out, 1);
      check("basic_bsh_data", bus.bsh_data_out, 8'h81);
      check("basic_count", bus.count_out, 1);
      step();
      check("basic_valid", bus.valid_out, 1);
      check("basic_data", bus.data_out, 8'h03);
      step();
      check("basic_drained", bus.valid_out, 0);

      // modulo reduction
      drive(8'hA5, 8'd9, 1'b1);
      step();
      check("mod_shift_9", bus.bsh_shift_out, 1);
      drive(8'hA5, 8'd8, 1'b1);
      step();
      check("mod_shift_8", bus.bsh_shift_out, 0);
      drive(8'h3C, 8'd255, 1'b1);
      step();
      check("mod_shift_255", bus.bsh_shift_out, 7);
      drive(8'h00, 8'd0, 1'b0);
      repeat (3) step();
      check("mod_sb_empty", sb.size(), 0);

      // backpressure / capacity
      bus.ready_in = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         drive(8'(i), 8'd0, 1'b1);
         step();
      end
      drive(8'h00, 8'd0, 1'b0);
      check("cap_ready_out", bus.ready_out, 0);
      check("cap_count", bus.count_out, 4);
      check("cap_accepted", sb.size(), 5);
      bus.ready_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("cap_drain_count", bus.count_out, 4 - k);
         check("cap_drain_valid", bus.valid_out, 1);
      end
      step();
      check("cap_end_valid", bus.valid_out, 0);
      check("cap_sb_empty", sb.size(), 0);

      // hold stability
      bus.ready_in = 1'b0;
      drive(8'h12, 8'd0, 1'b1);
      step();
      drive(8'h34, 8'd0, 1'b1);
      step();
      drive(8'h00, 8'd0, 1'b0);
      check("hold_data0", bus.data_out, 8'h12);
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_data", bus.data_out, 8'h12);
         check("hold_valid", bus.valid_out, 1);
         check("hold_count", bus.count_out, 1);
      end
      bus.ready_in = 1'b1;
      step();
      check("hold_next_data", bus.data_out, 8'h34);
      check("hold_next_valid", bus.valid_out, 1);
      step();
      check("hold_end_valid", bus.valid_out, 0);

      // streaming
      for (int i = 0; i < 16; i++) begin
         drive(8'(i), 8'(i % 8), 1'b1);
         step();
         check("stream_count_le1", 32'(bus.count_out <= 1), 1);
         if (i >= 1) check("stream_valid", bus.valid_out, 1);
      end
      drive(8'h00, 8'd0, 1'b0);
      step();
      check("stream_last_valid", bus.valid_out, 1);
      step();
      check("stream_end_valid", bus.valid_out, 0);
      check("stream_sb_empty", sb.size(), 0);

      // reset mid-operation
      bus.ready_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(8'hA0 + 8'(i), 8'd0, 1'b1);
         step();
      end
      drive(8'h00, 8'd0, 1'b0);
      check("pre_rst_count", bus.count_out, 3);
      check("pre_rst_valid", bus.valid_out, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.valid_out, 0);
      check("mid_rst_count", bus.count_out, 0);
      check("mid_rst_ready", bus.ready_out, 1);
      check("mid_rst_data", bus.data_out, 0);
      check("mid_rst_bsh_data", bus.bsh_data_out, 0);
      sb.delete();
      step();
      rst = 1'b0;
      bus.ready_in = 1'b1;
      drive(8'h80, 8'd1, 1'b1);
      step();
      drive(8'h00, 8'd0, 1'b0);
      check("post_rst_count", bus.count_out, 1);
      step();
      check("post_rst_data", bus.data_out, 8'h01);
      check("post_rst_valid", bus.valid_out, 1);
      step();
      check("post_rst_sb_empty", sb.size(), 0);
      check("post_rst_idle", bus.valid_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
